shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
Iterative signed 32x32 multiplier that sits alongside the ALU in the execute stage and is driven by the same operand buses.
- Each iteration forms a partial product as the 32-bit bitwise AND of the multiplicand magnitude with the current multiplier bit replicated 32 times.
- The partial product is accumulated into a 64-bit product register.
- Returns the low 32 bits with an overflow flag and a one-cycle ready pulse, for the pipeline stall logic.

Parameters:
WIDTH, 32, operand/result width; iteration counter is clog2(WIDTH) bits; product register is 2*WIDTH bits.

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clock
data_operandA  input  WIDTH  multiplicand, two's complement; sampled only when ctrl_MULT=1
data_operandB  input  WIDTH  multiplier, two's complement; sampled only when ctrl_MULT=1
ctrl_MULT  input  1  start strobe; one-cycle pulse
data_result  output  WIDTH  low WIDTH bits of signed product; registered
data_exception  output  1  1 if signed product does not fit in WIDTH bits; registered
data_resultRDY  output  1  one-cycle pulse when data_result/data_exception are valid

Behaviour:
- Reset: state=IDLE, counter=0, product=0, operand regs=0, data_result=0, data_exception=0, data_resultRDY=0. Reset mid-operation aborts with no RDY pulse; reset has priority over ctrl_MULT.
- States: IDLE, RUN, DONE.
- IDLE:
  - ctrl_MULT=1 at edge N: latch |A| to mcand, |B| to mplier, and sign = A[31]^B[31]. Set product=0, counter=0, go to RUN.
  - Magnitude of 0x80000000 is 0x80000000, interpreted unsigned.
- RUN, one iteration per edge:
  - pp = mcand AND {WIDTH{mplier[counter]}}.
  - product += pp << counter (64-bit unsigned add).
  - counter++.
  - After iteration WIDTH-1 (edge N+32), go to DONE.
- DONE, edge N+33:
  - P = sign ? -product : product (64-bit two's complement).
  - data_result = P[31:0].
  - data_exception = 1 iff P[63:31] is not all-equal.
  - data_resultRDY = 1 for this cycle only; state goes to IDLE.
- Latency: RDY is high in the cycle after edge N+33 (33 cycles after the start edge) and low on the next edge unless a new result completes.
- data_result and data_exception hold their last values until the next DONE; they are not cleared on start.
- ctrl_MULT during RUN: abort the current operation, latch new operands, restart at counter=0. No RDY for the aborted operation.
- ctrl_MULT in the DONE cycle: the DONE results and RDY pulse still occur; the new operands are latched and RUN begins the next cycle.
- ctrl_MULT held high for multiple cycles: restarts every cycle, so only the last sampled operands complete. Callers must pulse it.
- Zero operand: product 0, result 0, exception 0 regardless of sign.
- Most negative result: 0x80000000 is representable with P[63:31] all ones, so no exception.

Test Plan:
- Reset, then A=3, B=5, ctrl_MULT pulse at edge 0 -> RDY=1 only in the cycle after edge 33; result=15, exception=0. RDY=0 in all other cycles.
- A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6 (-42), exception=0. Repeat with A=0, B=-5 -> result=0, exception=0.
- A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. A=0x80000000, B=1 -> result=0x80000000, exception=0.
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1. A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1.
- Start A=3, B=5, then pulse ctrl_MULT again at edge 10 with A=4, B=4 -> a single RDY in the cycle after edge 43 with result=16. No RDY near edge 33.
- Start a multiply; assert reset at edge 20 for one cycle -> all outputs 0, no RDY. Then a new start with A=2, B=9 -> result=18 after 33 cycles.

Source files
------------

// File: rtl/shift_add_mult.sv
// Iterative signed WIDTHxWIDTH shift-and-add multiplier; result and a one-cycle ready pulse 33 cycles after the start edge.
// No backpressure: a start strobe always wins and restarts the operation, so the caller must hold off until the ready pulse.
module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             sign;
  logic [PW-1:0]    product;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] pp;
  logic [PW-1:0]    pp_shifted;
  logic [PW-1:0]    product_sum;
  logic [PW-1:0]    p_signed;
  logic             p_fits;

  // Unsigned magnitudes: the most negative value maps onto itself, which is
  // exactly right once the register is read as unsigned.
  assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign mag_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  assign pp          = mcand & {WIDTH{mplier[counter]}};
  assign pp_shifted  = {{WIDTH{1'b0}}, pp} << counter;
  assign product_sum = product + pp_shifted;

  assign p_signed = sign ? (~product + 1'b1) : product;
  // Fits in WIDTH signed bits only when the top WIDTH+1 bits are a pure sign extension.
  assign p_fits   = (&p_signed[PW-1:WIDTH-1]) | ~(|p_signed[PW-1:WIDTH-1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctrl_MULT) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (ctrl_MULT) begin
          state_nxt = RUN;
        end else if (counter == CW'(WIDTH - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = ctrl_MULT ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter        <= '0;
      mcand          <= '0;
      mplier         <= '0;
      sign           <= 1'b0;
      product        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (state == DONE);

      if (state == DONE) begin
        data_result    <= p_signed[WIDTH-1:0];
        data_exception <= ~p_fits;
      end

      if (ctrl_MULT) begin
        mcand   <= mag_a;
        mplier  <= mag_b;
        sign    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        product <= '0;
        counter <= '0;
      end else if (state == RUN) begin
        product <= product_sum;
        counter <= counter + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed bench for shift_add_mult: a signed-arithmetic reference model checked every cycle,
// plus literal expectations for latency, results and exceptions of hand-worked vectors.
module tb_shift_add_mult;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  shift_add_mult #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: a start is sampled on an edge; 33 edges later the full signed
  // product is known and reported. A new start always replaces a pending one.
  logic        m_rdy = 1'b0;
  logic        m_exc = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  bit          m_busy = 0;
  int          m_cnt = 0;

  always @(posedge clock) begin
    longint full;
    if (reset) begin
      m_busy = 0;
      m_rdy  = 1'b0;
      m_res  = '0;
      m_exc  = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 33) begin
          full   = longint'($signed(m_a)) * longint'($signed(m_b));
          m_res  = full[31:0];
          m_exc  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
          m_rdy  = 1'b1;
          m_busy = 0;
        end
      end
      if (ctrl_MULT) begin
        m_busy = 1;
        m_cnt  = 0;
        m_a    = data_operandA;
        m_b    = data_operandB;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model rdy", {31'b0, data_resultRDY}, {31'b0, m_rdy});
      check("model result", data_result, m_res);
      check("model exception", {31'b0, data_exception}, {31'b0, m_exc});
    end
  end

  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
    int lat;
    lat = -1;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    check({nm, " latency"}, 32'(lat), 32'd33);
    check({nm, " result"}, data_result, er);
    check({nm, " exception"}, {31'b0, data_exception}, {31'b0, ee});
    @(negedge clock);
    check({nm, " rdy drops"}, {31'b0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int n_rdy;
    int first;
    logic [31:0] res_at;
    int rdy_idx[$];
    logic [31:0] rdy_res[$];

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset result", data_result, 32'd0);
    check("reset exception", {31'b0, data_exception}, 32'd0);
    check("reset rdy", {31'b0, data_resultRDY}, 32'd0);
    reset  = 1'b0;
    chk_en = 1;

    run_mul("3x5", 32'd3, 32'd5, 32'd15, 1'b0);
    run_mul("-7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    run_mul("0x-5", 32'd0, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_mul("2^16x2^16", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);
    run_mul("minx1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_mul("minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_mul("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);

    // Restart during RUN at edge 10: only the second operation reports, at edge 43.
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    n_rdy  = 0;
    first  = -1;
    res_at = '0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 10) begin
        data_operandA = 32'd4;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      if (data_resultRDY) begin
        n_rdy++;
        if (first < 0) begin
          first  = i;
          res_at = data_result;
        end
      end
    end
    check("restart rdy count", 32'(n_rdy), 32'd1);
    check("restart rdy edge", 32'(first), 32'd43);
    check("restart result", res_at, 32'd16);

    // Reset at edge 20 aborts the operation and clears the held outputs.
    data_operandA = 32'd11;
    data_operandB = 32'd13;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    n_rdy = 0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 20) reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      if (i == 20) begin
        check("abort result", data_result, 32'd0);
        check("abort exception", {31'b0, data_exception}, 32'd0);
      end
      if (data_resultRDY) n_rdy++;
    end
    check("abort no rdy", 32'(n_rdy), 32'd0);
    run_mul("2x9", 32'd2, 32'd9, 32'd18, 1'b0);

    // Start landing on the DONE edge: the finishing result still reports.
    data_operandA = 32'd6;
    data_operandB = 32'hFFFF_FFF9;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 33) begin
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        ctrl_MULT     = 1'b1;
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      if (data_resultRDY) begin
        rdy_idx.push_back(i);
        rdy_res.push_back(data_result);
      end
    end
    check("overlap rdy count", 32'(rdy_idx.size()), 32'd2);
    if (rdy_idx.size() == 2) begin
      check("overlap first edge", 32'(rdy_idx[0]), 32'd33);
      check("overlap first result", rdy_res[0], 32'hFFFF_FFD6);
      check("overlap second edge", 32'(rdy_idx[1]), 32'd66);
      check("overlap second result", rdy_res[1], 32'd25);
    end

    repeat (3) @(negedge clock);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
